// File: rtl/seq_pkg.sv
// seq_pkg: shared definitions for the sequence-engine scheduler.
//   state_t : FSM state encoding used by seq_sched
//   SEQ_W   : width of the engine sequence number
package seq_pkg;

   localparam int SEQ_W = 4;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_GRANT  = 3'd1,
      S_LAUNCH = 3'd2,
      S_RUN    = 3'd3,
      S_DONE   = 3'd4,
      S_ABORT  = 3'd5
   } state_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin winner select.
//   req : request vector, one bit per requester
//   ptr : highest-priority index for this pick
//   idx : first set req bit at or above ptr, wrapping modulo NREQ
//   any : high when at least one req bit is set (idx valid)
module rr_pick #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] ptr,
   output logic [$clog2(NREQ)-1:0] idx,
   output logic                    any
);

   localparam int IW = $clog2(NREQ);

   // Scan from the lowest priority (ptr+NREQ-1) up to ptr; the last hit
   // written is the one closest to ptr, so no early exit is needed.
   always_comb begin
      int j;
      idx = '0;
      any = 1'b0;
      for (int i = NREQ-1; i >= 0; i--) begin
         j = int'(ptr) + i;
         if (j >= NREQ) j = j - NREQ;
         if (req[j]) begin
            idx = IW'(j);
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/seq_sched.sv
// seq_sched: arbitrates NREQ requesters onto one sequence engine.
//   clk, rst   : clock, asynchronous active-high reset
//   req        : level request per requester
//   gnt        : one-hot grant, held from GRANT through DONE/ABORT
//   cmpl, err  : one-cycle pulse to the owner on completion / watchdog abort
//   owner      : grant holder index, 0 when idle
//   busy       : high outside IDLE
//   seq_start  : one-cycle launch pulse to the engine
//   seq_rst    : engine reset (reset and abort)
//   seq_done   : engine completion flag, honoured only in RUN
//   seq_no_in  : engine sequence number
//   seq_no_out : seq_no_in delayed one cycle while RUN, else 0
//   valid      : qualifies seq_no_out
module seq_sched
   import seq_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   output logic [NREQ-1:0]         gnt,
   output logic [NREQ-1:0]         cmpl,
   output logic [NREQ-1:0]         err,
   output logic [$clog2(NREQ)-1:0] owner,
   output logic                    busy,
   output logic                    seq_start,
   output logic                    seq_rst,
   input  logic                    seq_done,
   input  logic [SEQ_W-1:0]        seq_no_in,
   output logic [SEQ_W-1:0]        seq_no_out,
   output logic                    valid
);

   localparam int IW = $clog2(NREQ);
   localparam int WW = $clog2(TIMEOUT+1);
   localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT);

   state_t         state;
   logic [IW-1:0]  rr_ptr;
   logic [WW-1:0]  wdog;
   logic           ab_2nd;   // second ABORT cycle
   logic [IW-1:0]  pick_idx;
   logic           pick_any;
   logic [IW-1:0]  ptr_next;

   rr_pick #(.NREQ(NREQ)) u_pick (
      .req (req),
      .ptr (rr_ptr),
      .idx (pick_idx),
      .any (pick_any)
   );

   assign ptr_next = (owner == IW'(NREQ-1)) ? '0 : owner + 1'b1;

   // Outputs are registered and written on the edge entering the state
   // they belong to, so they line up exactly with the state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         rr_ptr     <= '0;
         wdog       <= '0;
         ab_2nd     <= 1'b0;
         gnt        <= '0;
         cmpl       <= '0;
         err        <= '0;
         owner      <= '0;
         busy       <= 1'b0;
         valid      <= 1'b0;
         seq_no_out <= '0;
         seq_start  <= 1'b0;
         seq_rst    <= 1'b1;
      end else begin
         cmpl      <= '0;
         err       <= '0;
         seq_start <= 1'b0;
         seq_rst   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (pick_any) begin
                  state <= S_GRANT;
                  owner <= pick_idx;
                  gnt   <= NREQ'(1) << pick_idx;
                  busy  <= 1'b1;
               end
            end
            S_GRANT: begin
               state     <= S_LAUNCH;
               seq_start <= 1'b1;
            end
            S_LAUNCH: begin
               state      <= S_RUN;
               wdog       <= '0;
               valid      <= 1'b1;
               seq_no_out <= seq_no_in;
            end
            S_RUN: begin
               // Completion takes priority over an expiring watchdog.
               if (seq_done) begin
                  state      <= S_DONE;
                  valid      <= 1'b0;
                  seq_no_out <= '0;
                  cmpl       <= gnt;
               end else if (wdog == WD_MAX) begin
                  state      <= S_ABORT;
                  valid      <= 1'b0;
                  seq_no_out <= '0;
                  err        <= gnt;
                  seq_rst    <= 1'b1;
                  ab_2nd     <= 1'b0;
               end else begin
                  // Below WD_MAX here, so the increment cannot pass it.
                  wdog       <= wdog + 1'b1;
                  seq_no_out <= seq_no_in;
               end
            end
            S_DONE: begin
               state  <= S_IDLE;
               gnt    <= '0;
               owner  <= '0;
               busy   <= 1'b0;
               rr_ptr <= ptr_next;
            end
            S_ABORT: begin
               if (!ab_2nd) begin
                  ab_2nd  <= 1'b1;
                  seq_rst <= 1'b1;
               end else begin
                  state  <= S_IDLE;
                  ab_2nd <= 1'b0;
                  gnt    <= '0;
                  owner  <= '0;
                  busy   <= 1'b0;
                  rr_ptr <= ptr_next;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_sched.sv
// tb_seq_sched: self-checking bench for seq_sched (NREQ=4, TIMEOUT=64).
// Outputs are sampled and inputs driven on the falling edge.
module tb_seq_sched;

   localparam int NREQ    = 4;
   localparam int TIMEOUT = 64;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [NREQ-1:0] req = '0;
   logic [NREQ-1:0] gnt, cmpl, err;
   logic [1:0]      owner;
   logic            busy, seq_start, seq_rst, valid;
   logic            seq_done = 1'b0;
   logic [3:0]      seq_no_in = 4'd0;
   logic [3:0]      seq_no_out;

   int n_chk = 0;
   int n_err = 0;
   int ptr   = 0;   // model round-robin pointer

   seq_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .gnt        (gnt),
      .cmpl       (cmpl),
      .err        (err),
      .owner      (owner),
      .busy       (busy),
      .seq_start  (seq_start),
      .seq_rst    (seq_rst),
      .seq_done   (seq_done),
      .seq_no_in  (seq_no_in),
      .seq_no_out (seq_no_out),
      .valid      (valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // First requester at or above p, wrapping.
   function automatic int model_pick(input logic [NREQ-1:0] r, input int p);
      for (int i = 0; i < NREQ; i++)
         if (r[(p + i) % NREQ]) return (p + i) % NREQ;
      return 0;
   endfunction

   // One clock: sample at the falling edge, check invariants, drive new data.
   task automatic cyc();
      @(negedge clk);
      chk("gnt_onehot0", 32'($onehot0(gnt)), 1);
      chk("cmpl_onehot0", 32'($onehot0(cmpl)), 1);
      chk("err_onehot0", 32'($onehot0(err)), 1);
      chk("seq_no_out", seq_no_out, valid ? seq_no_in : 4'd0);
      seq_no_in = 4'($urandom_range(0, 15));
   endtask

   // One complete run starting from an IDLE falling edge.
   // done_at: RUN cycle (0 = first) during which seq_done is raised; >TIMEOUT = never.
   task automatic run(input logic [NREQ-1:0] r, input int done_at,
                      input bit drop, input bit raise1, input bit scramble);
      int w;
      logic [NREQ-1:0] oh;
      req = r;
      w   = model_pick(r, ptr);
      oh  = NREQ'(1) << w;
      seq_done = 1'($urandom_range(0, 1));   // ignored outside RUN
      cyc();
      chk("grant_gnt", gnt, oh);
      chk("grant_owner", owner, w);
      chk("grant_busy", busy, 1);
      chk("grant_start", seq_start, 0);
      chk("grant_seq_rst", seq_rst, 0);
      seq_done = 1'($urandom_range(0, 1));
      cyc();
      chk("launch_start", seq_start, 1);
      chk("launch_gnt", gnt, oh);
      chk("launch_valid", valid, 0);
      for (int k = 0; k <= TIMEOUT; k++) begin
         cyc();
         chk("run_valid", valid, 1);
         chk("run_gnt", gnt, oh);
         chk("run_start", seq_start, 0);
         chk("run_cmpl", cmpl, 0);
         if (drop && k == 5) req[w] = 1'b0;
         if (raise1 && k == 8) req[1] = 1'b1;
         if (scramble) req = NREQ'($urandom_range(0, 15));
         seq_done = (k == done_at);
         if (k == done_at) break;
      end
      cyc();
      seq_done = 1'b0;
      chk("end_valid", valid, 0);
      chk("end_gnt", gnt, oh);
      if (done_at <= TIMEOUT) begin
         chk("done_cmpl", cmpl, oh);
         chk("done_err", err, 0);
         chk("done_seq_rst", seq_rst, 0);
      end else begin
         chk("abort_err", err, oh);
         chk("abort_cmpl", cmpl, 0);
         chk("abort_seq_rst1", seq_rst, 1);
         cyc();
         chk("abort_seq_rst2", seq_rst, 1);
         chk("abort_err2", err, 0);
         chk("abort_gnt2", gnt, oh);
      end
      cyc();
      chk("idle_gnt", gnt, 0);
      chk("idle_busy", busy, 0);
      chk("idle_owner", owner, 0);
      chk("idle_cmpl", cmpl, 0);
      chk("idle_err", err, 0);
      chk("idle_seq_rst", seq_rst, 0);
      ptr = (w + 1) % NREQ;
   endtask

   initial begin
      #1 rst = 1'b1;
      #1;
      chk("rst_gnt", gnt, 0);
      chk("rst_seq_rst", seq_rst, 1);
      chk("rst_busy", busy, 0);
      chk("rst_valid", valid, 0);
      repeat (2) cyc();
      rst = 1'b0;
      chk("rst_hold_seq_rst", seq_rst, 1);

      // fairness: all request, grants 0,1,2,3,0
      for (int n = 0; n < 5; n++) run(4'b1111, 10 + n, 0, 0, 0);

      // single: seq_done 40 cycles after seq_start; pointer then sits at 3
      run(4'b0100, 39, 0, 0, 0);
      run(4'b1111, 3, 0, 0, 0);

      // timeout abort, then done on the very watchdog limit
      run(4'b0010, TIMEOUT + 1, 0, 0, 0);
      run(4'b1000, TIMEOUT, 0, 0, 0);

      // drop own req mid-RUN, index 1 raises during RUN
      run(4'b0001, 20, 1, 1, 0);
      run(4'b0010, 4, 0, 0, 0);

      // randomized runs
      for (int n = 0; n < 12; n++)
         run(NREQ'($urandom_range(1, 15)), $urandom_range(0, TIMEOUT + 8), 0, 0, 1);

      // reset during RUN
      req = 4'b0100;
      repeat (5) cyc();
      chk("pre_rst_valid", valid, 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_gnt", gnt, 0);
      chk("arst_busy", busy, 0);
      chk("arst_valid", valid, 0);
      chk("arst_owner", owner, 0);
      chk("arst_seq_no_out", seq_no_out, 0);
      chk("arst_seq_start", seq_start, 0);
      chk("arst_seq_rst", seq_rst, 1);
      chk("arst_cmpl", cmpl, 0);
      chk("arst_err", err, 0);
      repeat (3) begin
         cyc();
         chk("rsthold_cmpl", cmpl, 0);
         chk("rsthold_err", err, 0);
         chk("rsthold_gnt", gnt, 0);
      end
      rst = 1'b0;
      ptr = 0;
      run(4'b0001, 7, 0, 0, 0);

      req = '0;
      repeat (3) cyc();
      chk("final_busy", busy, 0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL sim_timeout got %0d exp %0d", n_chk, 0);
      $fatal(1, "bench time limit");
   end

endmodule

// File: doc/seq_sched.md
SEQ_SCHED -- requirements
Module: seq_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4, giving the number of requesters sharing one sequence engine (legal range 2..8).
REQ-002 SHALL have parameter TIMEOUT, default 64, giving the maximum number of RUN cycles before abort (legal range 16..255).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on the posedge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port req, input, NREQ bits: level request per requester.
REQ-006 SHALL have port gnt, output, NREQ bits: one-hot grant, held from GRANT through DONE/ABORT.
REQ-007 SHALL have port cmpl, output, NREQ bits: one-cycle pulse to the owner on successful completion.
REQ-008 SHALL have port err, output, NREQ bits: one-cycle pulse to the owner on watchdog abort.
REQ-009 SHALL have port owner, output, $clog2(NREQ) bits: index of the current grant holder; 0 when idle.
REQ-010 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 SHALL have port seq_start, output, 1 bit: start pulse to the sequence engine.
REQ-012 SHALL have port seq_rst, output, 1 bit: engine reset, used on abort.
REQ-013 SHALL have port seq_done, input, 1 bit: engine completion flag.
REQ-014 SHALL have port seq_no_in, input, 4 bits: the engine's current sequence number.
REQ-015 SHALL have port seq_no_out, output, 4 bits: seq_no_in registered to the owner; 0 outside RUN.
REQ-016 SHALL have port valid, output, 1 bit: high while seq_no_out carries RUN data.

Function
REQ-017 SHALL implement the FSM states IDLE, GRANT, LAUNCH, RUN, DONE and ABORT; all outputs SHALL be registered.
REQ-018 IDLE -> GRANT when any req bit is high.
- Winner: first set bit at or above the round-robin pointer rr_ptr, wrapping modulo NREQ.
- The winner SHALL be latched into owner and gnt.
REQ-019 GRANT -> LAUNCH after exactly 1 cycle.
REQ-020 In LAUNCH, seq_start SHALL be high for exactly that 1 cycle; LAUNCH -> RUN unconditionally.
REQ-021 RUN, watchdog and forwarding:
- The watchdog counter wdog ($clog2(TIMEOUT+1) bits) SHALL clear on entry and increment each cycle, saturating at TIMEOUT.
- valid SHALL be 1 in RUN.
- seq_no_out SHALL equal seq_no_in delayed by one cycle.
REQ-022 RUN -> DONE on seq_done=1.
- seq_done SHALL be ignored in all other states.
- seq_done and wdog==TIMEOUT in the same cycle: seq_done wins.
REQ-023 RUN -> ABORT when wdog==TIMEOUT and seq_done=0.
REQ-024 In DONE (1 cycle), then -> IDLE:
- cmpl[owner] pulses.
- gnt clears at exit.
- rr_ptr SHALL be set to (owner+1) mod NREQ.
REQ-025 In ABORT (2 cycles), then -> IDLE:
- seq_rst is high for both cycles.
- err[owner] pulses in the first cycle.
- rr_ptr is advanced as in REQ-024.
REQ-026 A req deasserted after grant SHALL NOT cancel the run; the run completes or aborts normally.
REQ-027 req bits arriving outside IDLE SHALL be held off; arbitration occurs only in IDLE, so the minimum gap between two runs is 1 IDLE cycle.
REQ-028 gnt, cmpl and err SHALL each always be one-hot or zero.

Reset
REQ-029 While rst=1, asynchronously:
- state=IDLE, rr_ptr=0, wdog=0.
- gnt=0, cmpl=0, err=0, owner=0, busy=0, valid=0, seq_no_out=0.
- seq_start=0, seq_rst=1.
REQ-030 seq_rst SHALL deassert on the first clock edge after rst falls.
REQ-031 Reset during RUN SHALL drop the grant with no cmpl/err pulse.

Structure
REQ-032 A shared package seq_pkg SHALL hold the FSM state encoding constants and the seq_no width (4).
REQ-033 The round-robin winner select SHALL be a combinational sub-module rr_pick (inputs: req, ptr; output: index plus any-valid flag); the FSM, watchdog and registers SHALL live in seq_sched.

Verification
REQ-034 The bench SHALL cover these directed scenarios:
- Single: req=4'b0100 held; engine model raises seq_done 40 cycles after seq_start -> gnt=4'b0100, seq_start one pulse 2 cycles after req, cmpl=4'b0100 one pulse, rr_ptr=3.
- Fairness: req=4'b1111 held for 4 runs -> grant order 0,1,2,3, then 0 again.
- Timeout (TIMEOUT=64): engine never sets seq_done -> ABORT 64 cycles after RUN entry, seq_rst high 2 cycles, err[owner] pulses, cmpl stays 0.
- Tie: seq_done and wdog==TIMEOUT in the same cycle -> cmpl pulses, no err, no seq_rst.
- Drop: owner drops req mid-RUN -> run continues, cmpl still pulses; a req from index 1 raised during RUN is granted only after the next IDLE cycle.
- Reset: rst asserted mid-RUN -> all outputs 0 and seq_rst=1 immediately without a clock; after release, first req=4'b0001 is granted to index 0.
